// File: rtl/commit_cu.sv
// Commit control unit: retires the ROB head, raises commit strobes and sequences flushes, fences and WFI sleep.
// Optional macro LEN5_FP_EN enables floating-point register-file commits; otherwise FP heads trap.

package commit_cu_pkg;

  typedef enum logic [3:0] {
    COMM_NONE,
    COMM_INT_RF,
    COMM_FP_RF,
    COMM_INT_RF_FP,
    COMM_LOAD,
    COMM_LOAD_FP,
    COMM_STORE,
    COMM_BRANCH,
    COMM_JUMP,
    COMM_CSR,
    COMM_FENCE,
    COMM_ECALL,
    COMM_EBREAK,
    COMM_EXCEPT,
    COMM_MRET,
    COMM_WFI
  } comm_type_t;

endpackage

module commit_cu
  import commit_cu_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  comm_type_t           comm_type_i,
  input  logic                 mispredict_i,
  input  logic                 store_ready_i,
  input  logic                 mem_idle_i,
  input  logic                 irq_i,
  output logic                 int_rf_we_o,
  output logic                 fp_rf_we_o,
  output logic                 csr_we_o,
  output logic                 sb_commit_o,
  output logic                 flush_o,
  output logic                 except_o,
  output logic                 mret_o,
  output logic                 wfi_o,
  output logic [INSTRET_W-1:0] instret_o
);

  typedef enum logic [2:0] {
    S_RESET,
    S_COMMIT,
    S_WAIT_FENCE,
    S_FLUSH,
    S_WFI
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [INSTRET_W-1:0]  instret_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes are Mealy so a head retires in the same cycle it becomes valid.
  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    int_rf_we_o = 1'b0;
    fp_rf_we_o  = 1'b0;
    csr_we_o    = 1'b0;
    sb_commit_o = 1'b0;
    flush_o     = 1'b0;
    except_o    = 1'b0;
    mret_o      = 1'b0;
    wfi_o       = 1'b0;

    case (state_q)
      S_RESET: begin
        state_d = S_COMMIT;
      end

      S_COMMIT: begin
        if (irq_i) begin
          // Interrupt is taken before the head; the head stays in the ROB and is replayed.
          except_o = 1'b1;
          flush_o  = 1'b1;
          state_d  = S_FLUSH;
        end else if (valid_i) begin
          case (comm_type_i)
            COMM_NONE: begin
              ready_o = 1'b1;
            end
            COMM_INT_RF, COMM_LOAD: begin
              int_rf_we_o = 1'b1;
              ready_o     = 1'b1;
            end
`ifdef LEN5_FP_EN
            COMM_FP_RF, COMM_LOAD_FP: begin
              fp_rf_we_o = 1'b1;
              ready_o    = 1'b1;
            end
            COMM_INT_RF_FP: begin
              int_rf_we_o = 1'b1;
              csr_we_o    = 1'b1;
              ready_o     = 1'b1;
            end
`else
            COMM_FP_RF, COMM_LOAD_FP, COMM_INT_RF_FP: begin
              except_o = 1'b1;
              flush_o  = 1'b1;
              ready_o  = 1'b1;
              state_d  = S_FLUSH;
            end
`endif
            COMM_STORE: begin
              sb_commit_o = store_ready_i;
              ready_o     = store_ready_i;
            end
            COMM_BRANCH, COMM_JUMP: begin
              ready_o     = 1'b1;
              int_rf_we_o = (comm_type_i == COMM_JUMP);
              if (mispredict_i) begin
                flush_o = 1'b1;
                state_d = S_FLUSH;
              end
            end
            COMM_CSR: begin
              csr_we_o    = 1'b1;
              int_rf_we_o = 1'b1;
              ready_o     = 1'b1;
              flush_o     = 1'b1;
              state_d     = S_FLUSH;
            end
            COMM_FENCE: begin
              state_d = S_WAIT_FENCE;
            end
            COMM_ECALL, COMM_EBREAK, COMM_EXCEPT: begin
              except_o = 1'b1;
              flush_o  = 1'b1;
              ready_o  = 1'b1;
              state_d  = S_FLUSH;
            end
            COMM_MRET: begin
              mret_o  = 1'b1;
              flush_o = 1'b1;
              ready_o = 1'b1;
              state_d = S_FLUSH;
            end
            COMM_WFI: begin
              ready_o = 1'b1;
              state_d = S_WFI;
            end
            default: begin
              state_d = S_COMMIT;
            end
          endcase
        end
      end

      S_WAIT_FENCE: begin
        // The fence retires only once memory drains; interrupts wait until afterwards.
        if (mem_idle_i) begin
          ready_o = 1'b1;
          flush_o = 1'b1;
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        state_d = S_COMMIT;
      end

      S_WFI: begin
        wfi_o = 1'b1;
        if (irq_i) begin
          state_d = S_COMMIT;
        end
      end

      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // Trapping heads leave the ROB but are not counted as retired.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else if (valid_i && ready_o && !except_o) begin
      instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_commit_cu.sv
// Self-checking bench for commit_cu: directed scenarios then randomized heads, checked each cycle
// against a rule-level reference model.

module tb_commit_cu;
  import commit_cu_pkg::*;

  localparam int IW = 6;
`ifdef LEN5_FP_EN
  localparam bit FP_EN = 1'b1;
`else
  localparam bit FP_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  comm_type_t    comm_type_i = COMM_NONE;
  logic          mispredict_i = 1'b0;
  logic          store_ready_i = 1'b0;
  logic          mem_idle_i = 1'b0;
  logic          irq_i = 1'b0;
  logic          int_rf_we_o, fp_rf_we_o, csr_we_o, sb_commit_o;
  logic          flush_o, except_o, mret_o, wfi_o;
  logic [IW-1:0] instret_o;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: which phase the commit stage is in, plus the retired count.
  bit booting, draining, fencing, sleeping;
  int retired;

  typedef struct packed {
    bit ready, int_we, fp_we, csr_we, sb, flush, exc, mret, wfi;
    bit to_flush, to_fence, to_sleep;
  } exp_t;

  commit_cu #(.INSTRET_W(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .comm_type_i(comm_type_i), .mispredict_i(mispredict_i),
    .store_ready_i(store_ready_i), .mem_idle_i(mem_idle_i), .irq_i(irq_i),
    .int_rf_we_o(int_rf_we_o), .fp_rf_we_o(fp_rf_we_o), .csr_we_o(csr_we_o),
    .sb_commit_o(sb_commit_o), .flush_o(flush_o), .except_o(except_o),
    .mret_o(mret_o), .wfi_o(wfi_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    comm_type_t t;
    e = '0;
    t = comm_type_i;
    if (booting || draining) begin
      e = '0;
    end else if (fencing) begin
      e.ready = mem_idle_i;
      e.flush = mem_idle_i;
    end else if (sleeping) begin
      e.wfi = 1'b1;
    end else if (irq_i) begin
      e.exc = 1'b1; e.flush = 1'b1; e.to_flush = 1'b1;
    end else if (valid_i) begin
      if (!FP_EN && (t == COMM_FP_RF || t == COMM_LOAD_FP || t == COMM_INT_RF_FP))
        t = COMM_EXCEPT;
      e.ready = 1'b1;
      case (t)
        COMM_INT_RF, COMM_LOAD: e.int_we = 1'b1;
        COMM_FP_RF, COMM_LOAD_FP: e.fp_we = 1'b1;
        COMM_INT_RF_FP: begin e.int_we = 1'b1; e.csr_we = 1'b1; end
        COMM_STORE: begin e.ready = store_ready_i; e.sb = store_ready_i; end
        COMM_BRANCH, COMM_JUMP: begin
          e.int_we = (t == COMM_JUMP);
          e.flush = mispredict_i; e.to_flush = mispredict_i;
        end
        COMM_CSR: begin e.csr_we = 1'b1; e.int_we = 1'b1; e.flush = 1'b1; e.to_flush = 1'b1; end
        COMM_FENCE: begin e.ready = 1'b0; e.to_fence = 1'b1; end
        COMM_ECALL, COMM_EBREAK, COMM_EXCEPT: begin e.exc = 1'b1; e.flush = 1'b1; e.to_flush = 1'b1; end
        COMM_MRET: begin e.mret = 1'b1; e.flush = 1'b1; e.to_flush = 1'b1; end
        COMM_WFI: e.to_sleep = 1'b1;
        default: ;
      endcase
    end
    return e;
  endfunction

  // Drive one cycle of inputs, check all outputs mid-cycle, then advance the model at the clock edge.
  task automatic applyStimulus(input bit v, input comm_type_t t, input bit mp, input bit sr,
                               input bit mi, input bit irq);
    exp_t e;
    valid_i = v; comm_type_i = t; mispredict_i = mp;
    store_ready_i = sr; mem_idle_i = mi; irq_i = irq;
    @(negedge clk_i);
    e = predict();
    checkOutput("ready", ready_o, e.ready);
    checkOutput("int_rf_we", int_rf_we_o, e.int_we);
    checkOutput("fp_rf_we", fp_rf_we_o, e.fp_we);
    checkOutput("csr_we", csr_we_o, e.csr_we);
    checkOutput("sb_commit", sb_commit_o, e.sb);
    checkOutput("flush", flush_o, e.flush);
    checkOutput("except", except_o, e.exc);
    checkOutput("mret", mret_o, e.mret);
    checkOutput("wfi", wfi_o, e.wfi);
    checkOutput("instret", instret_o, retired);
    @(posedge clk_i);
    if (v && e.ready && !e.exc) retired = (retired + 1) % (1 << IW);
    if (booting) booting = 1'b0;
    else if (draining) draining = 1'b0;
    else if (fencing) begin
      if (mi) begin fencing = 1'b0; draining = 1'b1; end
    end else if (sleeping) begin
      if (irq) sleeping = 1'b0;
    end else begin
      draining = e.to_flush;
      fencing  = e.to_fence;
      sleeping = e.to_sleep;
    end
    #1;
  endtask

  // Asynchronous reset pulse raised mid-cycle; outputs must clear before any clock edge.
  task automatic doReset();
    rst_i = 1'b1;
    #2;
    checkOutput("rst_ready", ready_o, 0);
    checkOutput("rst_strobes", {int_rf_we_o, fp_rf_we_o, csr_we_o, sb_commit_o,
                                flush_o, except_o, mret_o, wfi_o}, 0);
    checkOutput("rst_instret", instret_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    booting = 1'b1; draining = 1'b0; fencing = 1'b0; sleeping = 1'b0;
    retired = 0;
  endtask

  initial begin
    comm_type_t rt;
    @(posedge clk_i); #1;
    doReset();

    // Boot cycle, then three back-to-back integer heads.
    applyStimulus(1, COMM_INT_RF, 0, 0, 0, 0);
    repeat (3) applyStimulus(1, COMM_INT_RF, 0, 0, 0, 0);
    checkOutput("instret_after_3", instret_o, 3);

    // Store stalled four cycles on the store buffer.
    repeat (4) applyStimulus(1, COMM_STORE, 0, 0, 0, 0);
    applyStimulus(1, COMM_STORE, 0, 1, 0, 0);
    checkOutput("instret_after_store", instret_o, 4);

    // Mispredicted branch followed by its flush bubble.
    applyStimulus(1, COMM_BRANCH, 1, 0, 0, 0);
    applyStimulus(1, COMM_INT_RF, 0, 0, 0, 0);

    // Fence waiting on memory with an interrupt that must be held off.
    applyStimulus(1, COMM_FENCE, 0, 0, 0, 0);
    repeat (5) applyStimulus(1, COMM_FENCE, 0, 0, 0, 1);
    applyStimulus(1, COMM_FENCE, 0, 0, 1, 1);
    applyStimulus(0, COMM_NONE, 0, 0, 0, 0);

    // WFI sleep then wake-up by interrupt, which is taken next cycle.
    applyStimulus(1, COMM_WFI, 0, 0, 0, 0);
    repeat (10) applyStimulus(0, COMM_NONE, 0, 0, 0, 0);
    applyStimulus(0, COMM_NONE, 0, 0, 0, 1);
    applyStimulus(1, COMM_INT_RF, 0, 0, 0, 1);
    applyStimulus(0, COMM_NONE, 0, 0, 0, 0);

    // FP head and MRET / CSR serialisation.
    applyStimulus(1, COMM_FP_RF, 0, 0, 0, 0);
    applyStimulus(0, COMM_NONE, 0, 0, 0, 0);
    applyStimulus(1, COMM_CSR, 0, 0, 0, 0);
    applyStimulus(0, COMM_NONE, 0, 0, 0, 0);
    applyStimulus(1, COMM_MRET, 0, 0, 0, 0);
    applyStimulus(0, COMM_NONE, 0, 0, 0, 0);

    // Reset in the middle of a fence wait.
    applyStimulus(1, COMM_FENCE, 0, 0, 0, 0);
    applyStimulus(1, COMM_FENCE, 0, 0, 0, 0);
    doReset();
    applyStimulus(1, COMM_INT_RF, 0, 0, 0, 0);

    // Randomized heads with occasional reset pulses; long enough to wrap the counter.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) doReset();
      rt = comm_type_t'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 3) != 0, rt, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 4) < 3, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 19) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/commit_cu.md
COMMIT_CU -- requirements
Module: commit_cu

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64, width of the retired-instruction counter.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  ROB head is complete and ready to commit.
REQ-005 SHALL have port ready_o  output  1  head retired this cycle; ROB pops on valid_i && ready_o.
REQ-006 SHALL have port comm_type_i  input  comm_type_t  commit type of the head, from the commit decoder.
REQ-007 SHALL have port mispredict_i  input  1  head branch/jump was mispredicted.
REQ-008 SHALL have port store_ready_i  input  1  store buffer accepts a store commit.
REQ-009 SHALL have port mem_idle_i  input  1  no outstanding memory operations.
REQ-010 SHALL have port irq_i  input  1  interrupt pending.
REQ-011 SHALL have ports int_rf_we_o, fp_rf_we_o, csr_we_o, sb_commit_o  output  1 each  commit strobes.
REQ-012 SHALL have ports flush_o, except_o, mret_o, wfi_o  output  1 each  pipeline flush, trap entry, trap return, sleeping.
REQ-013 SHALL have port instret_o  output  INSTRET_W  retired-instruction count.

Function
REQ-014 SHALL implement FSM states S_RESET, S_COMMIT, S_WAIT_FENCE, S_FLUSH, S_WFI.
REQ-015 All strobes SHALL be combinational (Mealy) from state and inputs, with zero latency to valid_i; they SHALL be 0 unless stated below.
REQ-016 S_RESET: ready_o=0, no strobes; next state S_COMMIT unconditionally.
REQ-017 S_COMMIT, irq_i=1: except_o=1, flush_o=1, ready_o=0 (head not retired); next state S_FLUSH; irq_i SHALL have priority over any head type.
REQ-018 S_COMMIT, valid_i=0: idle; stay.
REQ-019 INT_RF, LOAD: int_rf_we_o=1, ready_o=1.
REQ-020 FP_RF, LOAD_FP: fp_rf_we_o=1, ready_o=1; INT_RF_FP: int_rf_we_o=1, csr_we_o=1 (fflags), ready_o=1.
REQ-021 STORE: sb_commit_o=ready_o=store_ready_i; stall in S_COMMIT while store_ready_i=0.
REQ-022 BRANCH: ready_o=1; JUMP: ready_o=1, int_rf_we_o=1; if mispredict_i, also flush_o=1 and go to S_FLUSH.
REQ-023 CSR: csr_we_o=1, int_rf_we_o=1, ready_o=1, flush_o=1; go to S_FLUSH (serialising).
REQ-024 FENCE: ready_o=0; go to S_WAIT_FENCE.
REQ-025 ECALL, EBREAK, EXCEPT: except_o=1, flush_o=1, ready_o=1; go to S_FLUSH.
REQ-026 MRET: mret_o=1, flush_o=1, ready_o=1; go to S_FLUSH.
REQ-027 WFI: ready_o=1; go to S_WFI. NONE: ready_o=1; stay.
REQ-028 S_WAIT_FENCE: ready_o=0 while mem_idle_i=0; when mem_idle_i=1: ready_o=1, flush_o=1, go to S_FLUSH; irq_i is ignored in this state.
REQ-029 S_FLUSH: exactly one cycle, ready_o=0, no strobes; go to S_COMMIT.
REQ-030 S_WFI: wfi_o=1, ready_o=0; on irq_i=1 go to S_COMMIT (the interrupt is then taken per REQ-017).
REQ-031 instret_o SHALL increment by 1 on each cycle with valid_i && ready_o && except_o==0, and SHALL wrap modulo 2^INSTRET_W.

Reset
REQ-032 rst_i=1 SHALL force state S_RESET and instret_o to 0 immediately, in any state including mid-stall or mid-fence; with state S_RESET, all outputs read 0.
REQ-033 The first commit after reset release SHALL occur no earlier than the second rising edge.

Configuration
REQ-034 Macro LEN5_FP_EN defined: FP_RF, LOAD_FP and INT_RF_FP behave per REQ-020.
REQ-035 LEN5_FP_EN undefined: fp_rf_we_o SHALL be tied 0; FP_RF, LOAD_FP and INT_RF_FP SHALL be handled as EXCEPT per REQ-025.

Verification
REQ-036 Reset, then 3 back-to-back INT_RF heads with valid_i=1 -> ready_o=1 and int_rf_we_o=1 for 3 cycles; instret_o=3.
REQ-037 STORE head with store_ready_i=0 for 4 cycles, then 1 -> sb_commit_o=ready_o=0 for 4 cycles, then 1 for one cycle; instret_o +1.
REQ-038 BRANCH with mispredict_i=1 -> ready_o=1 and flush_o=1 for 1 cycle, then 1 S_FLUSH cycle with ready_o=0.
REQ-039 FENCE with mem_idle_i=0 for 5 cycles; irq_i=1 asserted during the wait -> ready_o=0 and no except_o for 5 cycles; on mem_idle_i=1, ready_o=flush_o=1.
REQ-040 WFI, then irq_i=1 after 10 cycles -> wfi_o=1 for 10 cycles; next cycle except_o=1, ready_o=0.
REQ-041 FP_RF head, built without LEN5_FP_EN -> except_o=1, fp_rf_we_o=0, instret_o unchanged; rst_i pulse during S_WAIT_FENCE -> all outputs 0 and instret_o=0 at once.
